// File: rtl/src_ctl_pkg.sv
// Shared encodings for the Mini-SRC hardwired control unit: opcodes, ALU
// functions, bus driver selects, load-enable bit positions, FSM phases and
// the instruction classes the FSM switches on.
package src_ctl_pkg;

  localparam int OP_W  = 5;
  localparam int LD_W  = 12;
  localparam int BUS_W = 4;
  localparam int ALU_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_LD   = 5'b00000, OP_LDI, OP_ST,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
    OP_ADDI, OP_ANDI, OP_ORI,
    OP_MUL, OP_DIV, OP_NEG, OP_NOT,
    OP_BRX, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
    OP_NOP, OP_HALT
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_SHR, ALU_SHRA, ALU_SHL,
    ALU_ROR, ALU_ROL, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT
  } alu_e;

  localparam logic [BUS_W-1:0] BUS_NONE   = 4'd0;
  localparam logic [BUS_W-1:0] BUS_PC     = 4'd1;
  localparam logic [BUS_W-1:0] BUS_ZLO    = 4'd2;
  localparam logic [BUS_W-1:0] BUS_ZHI    = 4'd3;
  localparam logic [BUS_W-1:0] BUS_MDR    = 4'd4;
  localparam logic [BUS_W-1:0] BUS_REG    = 4'd5;
  localparam logic [BUS_W-1:0] BUS_C      = 4'd6;
  localparam logic [BUS_W-1:0] BUS_HI     = 4'd7;
  localparam logic [BUS_W-1:0] BUS_LO     = 4'd8;
  localparam logic [BUS_W-1:0] BUS_INPORT = 4'd9;

  localparam int LD_PC         = 0;
  localparam int LD_IR         = 1;
  localparam int LD_MAR        = 2;
  localparam int LD_MDR        = 3;
  localparam int LD_Y          = 4;
  localparam int LD_Z          = 5;
  localparam int LD_HI         = 6;
  localparam int LD_LO         = 7;
  localparam int LD_CON        = 8;
  localparam int LD_OUTPORT    = 9;
  localparam int LD_INC_PC     = 10;
  localparam int LD_MDR_MEMSEL = 11;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_e;

  // Instruction classes (bit positions of the one-hot class vector)
  localparam int CLS_LD     = 0;
  localparam int CLS_LDI    = 1;
  localparam int CLS_ST     = 2;
  localparam int CLS_ALU    = 3;
  localparam int CLS_IMM    = 4;
  localparam int CLS_MULDIV = 5;
  localparam int CLS_NEGNOT = 6;
  localparam int CLS_BRX    = 7;
  localparam int CLS_JR     = 8;
  localparam int CLS_JAL    = 9;
  localparam int CLS_IN     = 10;
  localparam int CLS_OUT    = 11;
  localparam int CLS_MFHI   = 12;
  localparam int CLS_MFLO   = 13;
  localparam int CLS_NOP    = 14;
  localparam int CLS_HALT   = 15;
  localparam int NCLS       = 16;

  // ALU function implied by an opcode; everything address-like adds.
  function automatic alu_e alu_of(logic [OP_W-1:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/src_op_decode.sv
// Opcode to one-hot instruction class. Halt and every unassigned opcode
// land in the HALT class so the FSM parks on anything it cannot execute.
module src_op_decode
  import src_ctl_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output logic [NCLS-1:0] cls_o
);

  // Pure lookup; exactly one class bit is always set.
  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_LD:                    cls_o[CLS_LD]     = 1'b1;
      OP_LDI:                   cls_o[CLS_LDI]    = 1'b1;
      OP_ST:                    cls_o[CLS_ST]     = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                                cls_o[CLS_ALU]    = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI: cls_o[CLS_IMM]    = 1'b1;
      OP_MUL, OP_DIV:           cls_o[CLS_MULDIV] = 1'b1;
      OP_NEG, OP_NOT:           cls_o[CLS_NEGNOT] = 1'b1;
      OP_BRX:                   cls_o[CLS_BRX]    = 1'b1;
      OP_JR:                    cls_o[CLS_JR]     = 1'b1;
      OP_JAL:                   cls_o[CLS_JAL]    = 1'b1;
      OP_IN:                    cls_o[CLS_IN]     = 1'b1;
      OP_OUT:                   cls_o[CLS_OUT]    = 1'b1;
      OP_MFHI:                  cls_o[CLS_MFHI]   = 1'b1;
      OP_MFLO:                  cls_o[CLS_MFLO]   = 1'b1;
      OP_NOP:                   cls_o[CLS_NOP]    = 1'b1;
      default:                  cls_o[CLS_HALT]   = 1'b1;
    endcase
  end

endmodule

// File: rtl/src_control_unit.sv
// Hardwired control FSM for the 3-bus Mini-SRC datapath. Fetch runs T0..T2,
// execute runs T3..T7 by instruction class. Outputs are decoded from the
// current phase and opcode; memory phases stall until mem_ready.
module src_control_unit
  import src_ctl_pkg::*;
#(
  parameter int OPW      = OP_W,
  parameter int NLD      = LD_W,
  parameter int BUS_SELW = BUS_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stop,
  input  logic                con_ff,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                run,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                rin,
  output logic                rout,
  output logic                ba_out,
  output logic [BUS_SELW-1:0] bus_src,
  output logic [NLD-1:0]      ld_en,
  output logic [ALU_W-1:0]    alu_op,
  output logic                mem_read,
  output logic                mem_write
);

  state_e          state_q, state_d;
  logic            armed_q;   // low from reset until the first edge after release
  logic            done_c;    // last phase of the current instruction
  logic [OPW-1:0]  opcode;
  logic [NCLS-1:0] cls;
  alu_e            op_alu;

  assign opcode = ir[31:27];
  assign op_alu = alu_of(opcode);
  assign run    = (state_q != HALT);

  // Register fields and the constant are consumed by the datapath's
  // select/encode and sign-extend logic, not here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  src_op_decode u_dec (
    .op_i  (opcode),
    .cls_o (cls)
  );

  // Phase register; reset parks in T0 with outputs gated off for one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= T0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next phase and control strobes from {phase, instruction class}.
  always_comb begin
    state_d   = state_q;
    done_c    = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    rin       = 1'b0;
    rout      = 1'b0;
    ba_out    = 1'b0;
    bus_src   = BUS_NONE;
    ld_en     = '0;
    alu_op    = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      T0: begin
        bus_src = BUS_PC;
        ld_en[LD_MAR] = 1'b1; ld_en[LD_INC_PC] = 1'b1; ld_en[LD_Z] = 1'b1;
        state_d = T1;
      end
      T1: begin
        bus_src = BUS_ZLO; mem_read = 1'b1;
        ld_en[LD_PC] = 1'b1; ld_en[LD_MDR_MEMSEL] = 1'b1; ld_en[LD_MDR] = 1'b1;
        if (mem_ready) state_d = T2;
      end
      T2: begin
        bus_src = BUS_MDR; ld_en[LD_IR] = 1'b1;
        state_d = T3;
      end
      HALT: state_d = HALT;
      default: begin
        unique case (1'b1)
          cls[CLS_ALU], cls[CLS_IMM]: begin
            case (state_q)
              T3: begin grb = 1'b1; rout = 1'b1; ld_en[LD_Y] = 1'b1; state_d = T4; end
              T4: begin
                if (cls[CLS_IMM]) bus_src = BUS_C;
                else begin grc = 1'b1; rout = 1'b1; end
                alu_op = op_alu; ld_en[LD_Z] = 1'b1; state_d = T5;
              end
              default: begin bus_src = BUS_ZLO; gra = 1'b1; rin = 1'b1; done_c = 1'b1; end
            endcase
          end
          cls[CLS_NEGNOT]: begin
            if (state_q == T3) begin
              grb = 1'b1; rout = 1'b1; alu_op = op_alu; ld_en[LD_Z] = 1'b1; state_d = T4;
            end else begin
              bus_src = BUS_ZLO; gra = 1'b1; rin = 1'b1; done_c = 1'b1;
            end
          end
          cls[CLS_MULDIV]: begin
            case (state_q)
              T3: begin gra = 1'b1; rout = 1'b1; ld_en[LD_Y] = 1'b1; state_d = T4; end
              T4: begin
                grb = 1'b1; rout = 1'b1; alu_op = op_alu; ld_en[LD_Z] = 1'b1; state_d = T5;
              end
              T5: begin bus_src = BUS_ZLO; ld_en[LD_LO] = 1'b1; state_d = T6; end
              default: begin bus_src = BUS_ZHI; ld_en[LD_HI] = 1'b1; done_c = 1'b1; end
            endcase
          end
          cls[CLS_LD], cls[CLS_LDI], cls[CLS_ST]: begin
            case (state_q)
              T3: begin grb = 1'b1; ba_out = 1'b1; ld_en[LD_Y] = 1'b1; state_d = T4; end
              T4: begin bus_src = BUS_C; ld_en[LD_Z] = 1'b1; state_d = T5; end
              T5: begin
                bus_src = BUS_ZLO;
                if (cls[CLS_LDI]) begin gra = 1'b1; rin = 1'b1; done_c = 1'b1; end
                else begin ld_en[LD_MAR] = 1'b1; state_d = T6; end
              end
              T6: begin
                if (cls[CLS_ST]) begin
                  gra = 1'b1; rout = 1'b1; ld_en[LD_MDR] = 1'b1; state_d = T7;
                end else begin
                  mem_read = 1'b1; ld_en[LD_MDR_MEMSEL] = 1'b1; ld_en[LD_MDR] = 1'b1;
                  if (mem_ready) state_d = T7;
                end
              end
              default: begin
                if (cls[CLS_ST]) begin
                  mem_write = 1'b1;
                  if (mem_ready) done_c = 1'b1;
                end else begin
                  bus_src = BUS_MDR; gra = 1'b1; rin = 1'b1; done_c = 1'b1;
                end
              end
            endcase
          end
          cls[CLS_BRX]: begin
            case (state_q)
              T3: begin gra = 1'b1; rout = 1'b1; ld_en[LD_CON] = 1'b1; state_d = T4; end
              T4: begin bus_src = BUS_PC; ld_en[LD_Y] = 1'b1; state_d = T5; end
              T5: begin bus_src = BUS_C; ld_en[LD_Z] = 1'b1; state_d = T6; end
              default: begin bus_src = BUS_ZLO; ld_en[LD_PC] = con_ff; done_c = 1'b1; end
            endcase
          end
          cls[CLS_JR]: begin gra = 1'b1; rout = 1'b1; ld_en[LD_PC] = 1'b1; done_c = 1'b1; end
          cls[CLS_JAL]: begin
            // T3 saves the return address into r15 (select logic maps grb to r15)
            if (state_q == T3) begin
              bus_src = BUS_PC; grb = 1'b1; rin = 1'b1; state_d = T4;
            end else begin
              gra = 1'b1; rout = 1'b1; ld_en[LD_PC] = 1'b1; done_c = 1'b1;
            end
          end
          cls[CLS_MFHI]: begin bus_src = BUS_HI; gra = 1'b1; rin = 1'b1; done_c = 1'b1; end
          cls[CLS_MFLO]: begin bus_src = BUS_LO; gra = 1'b1; rin = 1'b1; done_c = 1'b1; end
          cls[CLS_IN]:   begin bus_src = BUS_INPORT; gra = 1'b1; rin = 1'b1; done_c = 1'b1; end
          cls[CLS_OUT]:  begin gra = 1'b1; rout = 1'b1; ld_en[LD_OUTPORT] = 1'b1; done_c = 1'b1; end
          cls[CLS_NOP]:  done_c = 1'b1;
          default:       state_d = HALT;
        endcase
      end
    endcase

    // A register-file driver always owns the bus.
    if (rout || ba_out) bus_src = BUS_REG;

    // stop only takes effect between instructions.
    if (done_c) state_d = stop ? HALT : T0;

    if (!armed_q) begin
      state_d   = T0;
      gra       = 1'b0;
      grb       = 1'b0;
      grc       = 1'b0;
      rin       = 1'b0;
      rout      = 1'b0;
      ba_out    = 1'b0;
      bus_src   = BUS_NONE;
      ld_en     = '0;
      alu_op    = ALU_ADD;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_src_control_unit.sv
// Directed bench for src_control_unit. Each step pushes the expected output
// vector, advances the clock and pops/compares against the DUT.
module tb_src_control_unit;
  import src_ctl_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        stop = 1'b0, con_ff = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic        run, gra, grb, grc, rin, rout, ba_out, mem_read, mem_write;
  logic [3:0]  bus_src;
  logic [11:0] ld_en;
  logic [4:0]  alu_op;

  src_control_unit dut (
    .clock(clock), .reset_n(reset_n), .stop(stop), .con_ff(con_ff),
    .mem_ready(mem_ready), .ir(ir), .run(run), .gra(gra), .grb(grb), .grc(grc),
    .rin(rin), .rout(rout), .ba_out(ba_out), .bus_src(bus_src), .ld_en(ld_en),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clock = ~clock;

  logic [29:0] obs;
  assign obs = {run, gra, grb, grc, rin, rout, ba_out, bus_src, ld_en, alu_op,
                mem_read, mem_write};

  localparam logic [2:0] G0 = 3'b000, GA = 3'b100, GB = 3'b010, GC = 3'b001;
  localparam logic [2:0] NO = 3'b000, RIN = 3'b100, ROUT = 3'b010, BA = 3'b001;
  localparam logic [1:0] M0 = 2'b00, MR = 2'b10, MW = 2'b01;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [29:0] exp_q[$];
  string       tag_q[$];
  logic [29:0] E_RST, E_HALT, E_T0, E_T1, E_T2;

  function automatic logic [11:0] ldb(int i);
    return 12'b1 << i;
  endfunction

  // Expected vector with run=1; rrb = {rin, rout, ba_out}
  function automatic logic [29:0] ev(logic [2:0] g, logic [2:0] rrb, logic [3:0] bus,
                                     logic [11:0] ld, logic [4:0] alu, logic [1:0] mem);
    return {1'b1, g, rrb, bus, ld, alu, mem};
  endfunction

  task automatic check();
    logic [29:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic cyc(input string t, input logic [29:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
    check();
  endtask

  task automatic chk_now(input string t, input logic [29:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    check();
  endtask

  // From T0: T1 (held w extra cycles), T2. Leaves mem_ready low.
  task automatic fetch(input string t, input int w);
    cyc({t, "_T1"}, E_T1);
    mem_ready = 1'b0;
    repeat (w) cyc({t, "_T1w"}, E_T1);
    mem_ready = 1'b1;
    cyc({t, "_T2"}, E_T2);
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    E_RST  = ev(G0, NO, BUS_NONE, '0, ALU_ADD, M0);
    E_HALT = {1'b0, 29'd0};
    E_T0   = ev(G0, NO, BUS_PC, ldb(LD_MAR) | ldb(LD_INC_PC) | ldb(LD_Z), ALU_ADD, M0);
    E_T1   = ev(G0, NO, BUS_ZLO, ldb(LD_PC) | ldb(LD_MDR_MEMSEL) | ldb(LD_MDR), ALU_ADD, MR);
    E_T2   = ev(G0, NO, BUS_MDR, ldb(LD_IR), ALU_ADD, M0);

    // Reset for two clocks, release, T0 on the next edge
    #2 reset_n = 1'b0;
    cyc("rst_a", E_RST);
    cyc("rst_b", E_RST);
    reset_n = 1'b1;
    cyc("rel_T0", E_T0);

    // add r1,r2,r3 with mem_ready one cycle late
    ir = 32'h18918000;
    fetch("add", 1);
    cyc("add_T3", ev(GB, ROUT, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("add_T4", ev(GC, ROUT, BUS_REG, ldb(LD_Z), ALU_ADD, M0));
    cyc("add_T5", ev(GA, RIN, BUS_ZLO, '0, ALU_ADD, M0));
    cyc("add_T0", E_T0);

    // sub; mem_ready high in T0 must be ignored
    ir = {OP_SUB, 4'd4, 4'd5, 4'd6, 15'd0};
    mem_ready = 1'b1;
    fetch("sub", 0);
    cyc("sub_T3", ev(GB, ROUT, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("sub_T4", ev(GC, ROUT, BUS_REG, ldb(LD_Z), ALU_SUB, M0));
    cyc("sub_T5", ev(GA, RIN, BUS_ZLO, '0, ALU_ADD, M0));
    cyc("sub_T0", E_T0);

    // andi: immediate operand on the bus in T4
    ir = {OP_ANDI, 4'd1, 4'd2, 19'h7};
    fetch("andi", 0);
    cyc("andi_T3", ev(GB, ROUT, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("andi_T4", ev(G0, NO, BUS_C, ldb(LD_Z), ALU_AND, M0));
    cyc("andi_T5", ev(GA, RIN, BUS_ZLO, '0, ALU_ADD, M0));
    cyc("andi_T0", E_T0);

    // ld r1,0x55(r2): T6 stalls one cycle, then mem_ready
    ir = {OP_LD, 4'd1, 4'd2, 19'h55};
    fetch("ld", 0);
    cyc("ld_T3", ev(GB, BA, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("ld_T4", ev(G0, NO, BUS_C, ldb(LD_Z), ALU_ADD, M0));
    cyc("ld_T5", ev(G0, NO, BUS_ZLO, ldb(LD_MAR), ALU_ADD, M0));
    cyc("ld_T6", ev(G0, NO, BUS_NONE, ldb(LD_MDR_MEMSEL) | ldb(LD_MDR), ALU_ADD, MR));
    cyc("ld_T6w", ev(G0, NO, BUS_NONE, ldb(LD_MDR_MEMSEL) | ldb(LD_MDR), ALU_ADD, MR));
    mem_ready = 1'b1;
    cyc("ld_T7", ev(GA, RIN, BUS_MDR, '0, ALU_ADD, M0));
    mem_ready = 1'b0;
    cyc("ld_T0", E_T0);

    // brx with con_ff low then high
    for (int c = 0; c < 2; c++) begin
      con_ff = c[0];
      ir = {OP_BRX, 4'd3, 4'd0, 19'h20};
      fetch($sformatf("brx%0d", c), 0);
      cyc($sformatf("brx%0d_T3", c), ev(GA, ROUT, BUS_REG, ldb(LD_CON), ALU_ADD, M0));
      cyc($sformatf("brx%0d_T4", c), ev(G0, NO, BUS_PC, ldb(LD_Y), ALU_ADD, M0));
      cyc($sformatf("brx%0d_T5", c), ev(G0, NO, BUS_C, ldb(LD_Z), ALU_ADD, M0));
      cyc($sformatf("brx%0d_T6", c),
          ev(G0, NO, BUS_ZLO, (c == 1) ? ldb(LD_PC) : 12'd0, ALU_ADD, M0));
      cyc($sformatf("brx%0d_T0", c), E_T0);
    end
    con_ff = 1'b0;

    // mul with stop raised during T4: finishes, then HALT
    ir = {OP_MUL, 4'd2, 4'd3, 19'd0};
    fetch("mul", 0);
    cyc("mul_T3", ev(GA, ROUT, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("mul_T4", ev(GB, ROUT, BUS_REG, ldb(LD_Z), ALU_MUL, M0));
    stop = 1'b1;
    cyc("mul_T5", ev(G0, NO, BUS_ZLO, ldb(LD_LO), ALU_ADD, M0));
    cyc("mul_T6", ev(G0, NO, BUS_ZHI, ldb(LD_HI), ALU_ADD, M0));
    cyc("mul_HALT", E_HALT);
    stop = 1'b0;
    mem_ready = 1'b1;
    cyc("halt_hold", E_HALT);
    mem_ready = 1'b0;

    // Only reset leaves HALT
    reset_n = 1'b0;
    chk_now("rst_halt", E_RST);
    cyc("rst_halt_hold", E_RST);
    reset_n = 1'b1;
    cyc("st_rel_T0", E_T0);

    // st: reset asserted while mem_write is waiting in T7
    ir = {OP_ST, 4'd1, 4'd2, 19'h55};
    fetch("st", 0);
    cyc("st_T3", ev(GB, BA, BUS_REG, ldb(LD_Y), ALU_ADD, M0));
    cyc("st_T4", ev(G0, NO, BUS_C, ldb(LD_Z), ALU_ADD, M0));
    cyc("st_T5", ev(G0, NO, BUS_ZLO, ldb(LD_MAR), ALU_ADD, M0));
    cyc("st_T6", ev(GA, ROUT, BUS_REG, ldb(LD_MDR), ALU_ADD, M0));
    cyc("st_T7", ev(G0, NO, BUS_NONE, '0, ALU_ADD, MW));
    cyc("st_T7w", ev(G0, NO, BUS_NONE, '0, ALU_ADD, MW));
    #2 reset_n = 1'b0;
    chk_now("st_rst_async", E_RST);
    cyc("st_rst_hold", E_RST);
    reset_n = 1'b1;
    cyc("st_rst_T0", E_T0);

    // jal: link through grb/rin, then jump via gra/rout
    ir = {OP_JAL, 4'd5, 23'd0};
    fetch("jal", 0);
    cyc("jal_T3", ev(GB, RIN, BUS_PC, '0, ALU_ADD, M0));
    cyc("jal_T4", ev(GA, ROUT, BUS_REG, ldb(LD_PC), ALU_ADD, M0));
    cyc("jal_T0", E_T0);

    // Undefined opcode halts after T3
    ir = {5'b11110, 27'd0};
    fetch("undef", 0);
    cyc("undef_T3", E_RST);
    cyc("undef_HALT", E_HALT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
